add8u_err_sweeper: RTL and testbench
====================================

# add8u_err_sweeper

Exhaustive error-characterisation engine for the unsigned approximate adders in the library. It drives every operand pair into an external approximate adder and receives the adder's sum back on the same cycle. For each pair it compares that sum against the exact sum and accumulates the error statistics used in the library headers: mean-error numerator, mean-squared-error numerator, worst-case error, and error count. It sits immediately upstream (stimulus) and downstream (result consumer) of one combinational `add8u_*` instance.

## Interface
Parameters:
- `W`, default 8: operand width. Total vectors N = 2^(2W).

Ports (name, direction, width, meaning):
- `clk`, in, 1: the single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle request. It begins a sweep when sampled in IDLE or DONE.
- `op_a`, out, W: operand A to the adder under test.
- `op_b`, out, W: operand B to the adder under test.
- `approx_sum`, in, W+1: adder output, combinationally dependent on `op_a` and `op_b`.
- `busy`, out, 1: high in SWEEP and DRAIN.
- `done`, out, 1: high in DONE until the next accepted `start`.
- `sum_abs_err`, out, 3W+1: Σ|approx − exact|.
- `sum_sq_err`, out, 4W+2: Σ(approx − exact)².
- `max_err`, out, W+1: worst-case |error|.
- `err_cnt`, out, 2W+1: number of vectors with nonzero error.
- `wce_a`, out, W: operand A of the first vector, in sweep order, that reached `max_err`.
- `wce_b`, out, W: operand B of that same vector.

## Operation
- FSM states: IDLE, SWEEP, DRAIN, DONE.
  - IDLE → SWEEP on `start`.
  - SWEEP → DRAIN after the cycle in which vector N−1 is issued.
  - DRAIN → DONE after 2 cycles.
  - DONE → SWEEP on `start`.
- Accepting `start` clears all accumulators, `max_err`, `wce_a`, `wce_b` and the vector counter in the same edge.
- Vector counter `idx` is 2W bits; `{op_a, op_b} = idx`, so `op_b` varies fastest. It increments once per SWEEP cycle with no stalls.
- Outside SWEEP, `op_a` and `op_b` hold their last value.
- Exact sum = `op_a + op_b`, zero-extended to W+1 bits. Error is the signed difference; the absolute error fits in W+1 bits.
- Squared error is computed from the absolute error and fits in 2W+2 bits.
- Accumulator widths are sized so that overflow cannot occur for N vectors; no saturation logic is needed.
- `max_err`, `wce_a` and `wce_b` update only on a strictly greater error, so ties keep the earliest vector.
- `start` while `busy` is ignored.
- Results are stable and readable in DONE and in IDLE, and hold until the next accepted `start`.

## Timing
- Reset value of every output is 0; FSM resets to IDLE.
- `rst` asserted mid-sweep aborts immediately: all state and outputs return to 0 or IDLE, with no partial results retained.
- Pipeline, for a vector issued in cycle k:
  - S1 registers `approx_sum`, exact sum, `op_a` and `op_b` at the end of cycle k.
  - S2 registers the absolute and squared error at the end of cycle k+1.
  - Accumulators update at the end of cycle k+2.
- `start` sampled at edge e0:
  - Vector 0 is driven in the cycle after e0.
  - Vector N−1 is driven N cycles after e0.
  - `busy` rises at e0+1.
  - `done` rises at e0+N+3 and `busy` falls at the same edge.
- `start` in DONE: `done` falls and `busy` rises on the same edge.

## Structure
- Package `add_err_pkg`:
  - state enum `sweep_state_t`.
  - width functions for `W` (abs W+1, square 2W+2, sum-abs 3W+1, sum-square 4W+2, count 2W+1).
- Sub-module `add_err_stage`: S1 and S2 pipeline registers (exact sum, absolute error, square), with a valid bit.
- Top level holds the FSM, counter, accumulators and the worst-case tracker.

## Test plan
- Exact model adder, W=8, one sweep → `done` 65539 cycles after `start`; all statistics 0; `wce_a` = `wce_b` = 0.
- Model with `approx_sum = exact ^ 1` →
  - `sum_abs_err` = 65536, `sum_sq_err` = 65536, `err_cnt` = 65536.
  - `max_err` = 1; `wce_a` = 0, `wce_b` = 0.
- Model with `approx_sum = 0` →
  - `sum_abs_err` = 16711680, `sum_sq_err` = 4977295360, `err_cnt` = 65535.
  - `max_err` = 510; `wce_a` = 255, `wce_b` = 255.
- W=2 with the exact adder → `busy` high for exactly 18 cycles; `done` at e0+19; `op_a`/`op_b` step 0/0, 0/1 … 3/3.
- Pulse `start` during SWEEP → ignored; results identical to an uninterrupted sweep. A second `start` in DONE → statistics cleared and the sweep repeats with identical results.
- Assert `rst` at vector 30000 → all outputs 0 and state IDLE; a following `start` produces full, correct results.

Source files
------------

// File: rtl/add_err_pkg.sv
// Shared types and width helpers for the approximate-adder error sweeper.
package add_err_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } sweep_state_t;

    function automatic int unsigned abs_w(input int unsigned w);
        return w + 1;
    endfunction

    function automatic int unsigned sq_w(input int unsigned w);
        return 2 * w + 2;
    endfunction

    function automatic int unsigned sum_abs_w(input int unsigned w);
        return 3 * w + 1;
    endfunction

    function automatic int unsigned sum_sq_w(input int unsigned w);
        return 4 * w + 2;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/add_err_stage.sv
// Two-stage error pipeline: S1 captures operands, exact and approximate sums;
// S2 produces absolute and squared error, carrying the operands for worst-case tracking.
module add_err_stage
    import add_err_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [W-1:0]           a,
    input  logic [W-1:0]           b,
    input  logic [abs_w(W)-1:0]    approx_sum,
    output logic                   valid,
    output logic [abs_w(W)-1:0]    abs_err,
    output logic [sq_w(W)-1:0]     sq_err,
    output logic [W-1:0]           err_a,
    output logic [W-1:0]           err_b
);

    localparam int unsigned AW = abs_w(W);
    localparam int unsigned SW = sq_w(W);

    logic          s1_valid;
    logic [AW-1:0] s1_approx;
    logic [AW-1:0] s1_exact;
    logic [W-1:0]  s1_a;
    logic [W-1:0]  s1_b;
    logic [AW-1:0] abs_c;

    // S1: sample the adder under test together with the exact reference
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_approx <= '0;
            s1_exact  <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
        end else begin
            s1_valid  <= in_valid;
            s1_approx <= approx_sum;
            s1_exact  <= AW'(a) + AW'(b);
            s1_a      <= a;
            s1_b      <= b;
        end
    end

    always_comb begin
        abs_c = '0;
        if (s1_approx >= s1_exact) begin
            abs_c = s1_approx - s1_exact;
        end else begin
            abs_c = s1_exact - s1_approx;
        end
    end

    // S2: magnitude and square; the square of a (W+1)-bit value fits 2W+2 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= 1'b0;
            abs_err <= '0;
            sq_err  <= '0;
            err_a   <= '0;
            err_b   <= '0;
        end else begin
            valid   <= s1_valid;
            abs_err <= abs_c;
            sq_err  <= SW'(abs_c) * SW'(abs_c);
            err_a   <= s1_a;
            err_b   <= s1_b;
        end
    end

endmodule

// File: rtl/add8u_err_sweeper.sv
// Exhaustive error sweeper: walks every operand pair through an external
// approximate adder and accumulates MAE/MSE numerators, worst case and error count.
module add8u_err_sweeper
    import add_err_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [W-1:0]             op_a,
    output logic [W-1:0]             op_b,
    input  logic [abs_w(W)-1:0]      approx_sum,
    output logic                     busy,
    output logic                     done,
    output logic [sum_abs_w(W)-1:0]  sum_abs_err,
    output logic [sum_sq_w(W)-1:0]   sum_sq_err,
    output logic [abs_w(W)-1:0]      max_err,
    output logic [cnt_w(W)-1:0]      err_cnt,
    output logic [W-1:0]             wce_a,
    output logic [W-1:0]             wce_b
);

    localparam int unsigned IW  = 2 * W;
    localparam int unsigned AW  = abs_w(W);
    localparam int unsigned SW  = sq_w(W);
    localparam int unsigned SAW = sum_abs_w(W);
    localparam int unsigned SSW = sum_sq_w(W);
    localparam int unsigned CW  = cnt_w(W);

    sweep_state_t  state;
    logic [IW-1:0] idx;
    logic          drain_cnt;
    logic          accept_c;
    logic          last_c;

    logic          s2_valid;
    logic [AW-1:0] s2_abs;
    logic [SW-1:0] s2_sq;
    logic [W-1:0]  s2_a;
    logic [W-1:0]  s2_b;

    assign accept_c = start && ((state == S_IDLE) || (state == S_DONE));
    assign last_c   = (idx == {IW{1'b1}});

    // op_b is the low half so it varies fastest
    assign op_a = idx[IW-1:W];
    assign op_b = idx[W-1:0];

    // Sequencer; busy/done follow the state by one edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            drain_cnt <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy <= (state == S_SWEEP) || (state == S_DRAIN);
            done <= (state == S_DONE);
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_SWEEP;
                        idx   <= '0;
                    end
                end
                S_SWEEP: begin
                    if (last_c) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 1'b0;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt) begin
                        state <= S_DONE;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    add_err_stage #(
        .W(W)
    ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (state == S_SWEEP),
        .a          (op_a),
        .b          (op_b),
        .approx_sum (approx_sum),
        .valid      (s2_valid),
        .abs_err    (s2_abs),
        .sq_err     (s2_sq),
        .err_a      (s2_a),
        .err_b      (s2_b)
    );

    // Accumulators and worst-case tracker; strict compare keeps the earliest tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_abs_err <= '0;
            sum_sq_err  <= '0;
            err_cnt     <= '0;
            max_err     <= '0;
            wce_a       <= '0;
            wce_b       <= '0;
        end else if (accept_c) begin
            sum_abs_err <= '0;
            sum_sq_err  <= '0;
            err_cnt     <= '0;
            max_err     <= '0;
            wce_a       <= '0;
            wce_b       <= '0;
        end else if (s2_valid) begin
            sum_abs_err <= sum_abs_err + SAW'(s2_abs);
            sum_sq_err  <= sum_sq_err + SSW'(s2_sq);
            if (s2_abs != '0) begin
                err_cnt <= err_cnt + CW'(1);
            end
            if (s2_abs > max_err) begin
                max_err <= s2_abs;
                wce_a   <= s2_a;
                wce_b   <= s2_b;
            end
        end
    end

endmodule

// File: tb/tb_add8u_err_sweeper.sv
// Bench for add8u_err_sweeper: a W=8 instance runs one full sweep while a W=2
// instance covers timing, restart, ignored start and mid-sweep reset.
module tb_add8u_err_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8 = 1'b1, start8 = 1'b0;
    logic rst2 = 1'b1, start2 = 1'b0;
    int   mode8 = 2;
    int   mode2 = 0;

    logic [7:0]  op_a8, op_b8, wa8, wb8;
    logic [8:0]  approx8, max8;
    logic        busy8, done8;
    logic [24:0] sabs8;
    logic [33:0] ssq8;
    logic [16:0] cnt8;

    logic [1:0]  op_a2, op_b2, wa2, wb2;
    logic [2:0]  approx2, max2;
    logic        busy2, done2;
    logic [6:0]  sabs2;
    logic [9:0]  ssq2;
    logic [4:0]  cnt2;

    int checks = 0;
    int errors = 0;
    bit s8_fin = 0;
    bit s2_fin = 0;

    // Adder models placed under test: 0 exact, 1 exact^1, 2 constant zero, 3 arbitrary
    function automatic longint approx_fn(input int mode, input longint a, input longint b, input int w);
        longint ex;
        longint m;
        ex = a + b;
        m  = (longint'(1) << (w + 1)) - 1;
        case (mode)
            0:       return ex;
            1:       return ex ^ 1;
            2:       return 0;
            default: return ((a * 5) ^ (b * 3)) & m;
        endcase
    endfunction

    always_comb approx8 = 9'(approx_fn(mode8, longint'(op_a8), longint'(op_b8), 8));
    always_comb approx2 = 3'(approx_fn(mode2, longint'(op_a2), longint'(op_b2), 2));

    add8u_err_sweeper #(.W(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .op_a(op_a8), .op_b(op_b8),
        .approx_sum(approx8), .busy(busy8), .done(done8), .sum_abs_err(sabs8),
        .sum_sq_err(ssq8), .max_err(max8), .err_cnt(cnt8), .wce_a(wa8), .wce_b(wb8)
    );

    add8u_err_sweeper #(.W(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .op_a(op_a2), .op_b(op_b2),
        .approx_sum(approx2), .busy(busy2), .done(done2), .sum_abs_err(sabs2),
        .sum_sq_err(ssq2), .max_err(max2), .err_cnt(cnt2), .wce_a(wa2), .wce_b(wb2)
    );

    task automatic chk(input int id, input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL inst%0d %s at %0t: got %0d expected %0d", id, name, $time, act, exp);
        end
    endtask

    // Reference state per instance: t counts edges since the accepted start edge
    bit     run[2]      = '{0, 0};
    bit     pending[2]  = '{0, 0};
    bit     pend_dn[2]  = '{0, 0};
    bit     done0[2]    = '{0, 0};
    longint t[2]        = '{0, 0};
    longint m_abs[2]    = '{0, 0};
    longint m_sq[2]     = '{0, 0};
    longint m_cnt[2]    = '{0, 0};
    longint m_max[2]    = '{0, 0};
    longint m_wa[2]     = '{0, 0};
    longint m_wb[2]     = '{0, 0};

    task automatic clear_model(input int id);
        m_abs[id] = 0; m_sq[id] = 0; m_cnt[id] = 0;
        m_max[id] = 0; m_wa[id] = 0; m_wb[id] = 0;
    endtask

    task automatic check_cycle(input int id, input int w, input int mode,
                               input logic rst_v, input logic start_v,
                               input logic busy_v, input logic done_v,
                               input longint opa, input longint opb,
                               input longint sabs, input longint ssq, input longint mx,
                               input longint cnt, input longint wa, input longint wb);
        longint n, mask, v, a, b, e, idx_e;
        bit busy_e, done_e;
        n    = longint'(1) << (2 * w);
        mask = (longint'(1) << w) - 1;
        if (rst_v) begin
            run[id] = 0; pending[id] = 0;
            clear_model(id);
        end else if (pending[id]) begin
            pending[id] = 0; run[id] = 1; t[id] = 0;
            done0[id] = pend_dn[id];
            clear_model(id);
        end else if (run[id]) begin
            t[id]++;
        end
        // vector issued three cycles ago is now reflected in the statistics
        if (run[id] && t[id] >= 3 && t[id] - 3 < n) begin
            v = t[id] - 3;
            a = v >> w;
            b = v & mask;
            e = approx_fn(mode, a, b, w) - (a + b);
            if (e < 0) e = -e;
            m_abs[id] += e;
            m_sq[id]  += e * e;
            if (e != 0) m_cnt[id]++;
            if (e > m_max[id]) begin
                m_max[id] = e; m_wa[id] = a; m_wb[id] = b;
            end
        end
        if (!run[id]) begin
            busy_e = 0; done_e = 0; idx_e = 0;
        end else begin
            idx_e  = (t[id] < n) ? t[id] : n - 1;
            busy_e = (t[id] >= 1) && (t[id] <= n + 2);
            done_e = (t[id] == 0) ? done0[id] : (t[id] >= n + 3);
        end
        chk(id, "busy", longint'(busy_v), longint'(busy_e));
        chk(id, "done", longint'(done_v), longint'(done_e));
        chk(id, "op_a", opa, idx_e >> w);
        chk(id, "op_b", opb, idx_e & mask);
        chk(id, "sum_abs_err", sabs, m_abs[id]);
        chk(id, "sum_sq_err", ssq, m_sq[id]);
        chk(id, "err_cnt", cnt, m_cnt[id]);
        chk(id, "max_err", mx, m_max[id]);
        chk(id, "wce_a", wa, m_wa[id]);
        chk(id, "wce_b", wb, m_wb[id]);
        if (!rst_v && start_v && (!run[id] || t[id] >= n + 2)) begin
            pending[id] = 1;
            pend_dn[id] = run[id] && (t[id] >= n + 2);
        end
    endtask

    always @(negedge clk) begin
        check_cycle(0, 8, mode8, rst8, start8, busy8, done8, longint'(op_a8), longint'(op_b8),
                    longint'(sabs8), longint'(ssq8), longint'(max8), longint'(cnt8),
                    longint'(wa8), longint'(wb8));
        check_cycle(1, 2, mode2, rst2, start2, busy2, done2, longint'(op_a2), longint'(op_b2),
                    longint'(sabs2), longint'(ssq2), longint'(max2), longint'(cnt2),
                    longint'(wa2), longint'(wb2));
    end

    // W=2 sweep: optional start pulse after edge glitch_at, optional reset after edge rst_at
    task automatic sweep2(input int glitch_at, input int rst_at, output int cyc, output int busyc);
        bit seen;
        seen = 0;
        @(posedge clk); #2 start2 = 1'b1;
        @(posedge clk); #2 start2 = 1'b0;
        cyc = 0; busyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1;
            if (busy2) busyc++;
            if (done2) begin
                seen = 1;
                break;
            end
            #1;
            start2 = (cyc == glitch_at);
            if (cyc == rst_at) begin
                rst2 = 1'b1;
                repeat (2) @(posedge clk);
                #2 rst2 = 1'b0;
                return;
            end
        end
        start2 = 1'b0;
        if (!seen) chk(1, "done timeout", 0, 1);
    endtask

    initial begin : stim2
        int cyc, bc;
        repeat (3) @(posedge clk);
        #2 rst2 = 1'b0;
        repeat (2) @(posedge clk);

        mode2 = 0;
        sweep2(0, 0, cyc, bc);
        chk(1, "w2 done latency", cyc, 19);
        chk(1, "w2 busy cycles", bc, 18);
        chk(1, "exact sum_abs_err", longint'(sabs2), 0);
        chk(1, "exact max_err", longint'(max2), 0);

        mode2 = 1;
        sweep2(0, 0, cyc, bc);
        chk(1, "xor1 sum_abs_err", longint'(sabs2), 16);
        chk(1, "xor1 sum_sq_err", longint'(ssq2), 16);
        chk(1, "xor1 err_cnt", longint'(cnt2), 16);
        chk(1, "xor1 max_err", longint'(max2), 1);
        chk(1, "xor1 wce_a", longint'(wa2), 0);
        chk(1, "xor1 wce_b", longint'(wb2), 0);

        mode2 = 2;
        sweep2(0, 0, cyc, bc);
        chk(1, "zero sum_abs_err", longint'(sabs2), 48);
        chk(1, "zero sum_sq_err", longint'(ssq2), 184);
        chk(1, "zero err_cnt", longint'(cnt2), 15);
        chk(1, "zero max_err", longint'(max2), 6);
        chk(1, "zero wce_a", longint'(wa2), 3);
        chk(1, "zero wce_b", longint'(wb2), 3);

        mode2 = 3;
        sweep2(5, 0, cyc, bc);
        chk(1, "glitch done latency", cyc, 19);
        sweep2(0, 0, cyc, bc);
        chk(1, "restart done latency", cyc, 19);
        sweep2(0, 10, cyc, bc);
        repeat (3) @(posedge clk);
        #1;
        chk(1, "post-reset busy", longint'(busy2), 0);
        chk(1, "post-reset sum_abs_err", longint'(sabs2), 0);
        sweep2(0, 0, cyc, bc);
        chk(1, "after-reset done latency", cyc, 19);
        s2_fin = 1;
    end

    initial begin : stim8
        int cyc;
        bit seen;
        repeat (3) @(posedge clk);
        #2 rst8 = 1'b0;
        repeat (2) @(posedge clk);
        #2 start8 = 1'b1;
        @(posedge clk);
        #2 start8 = 1'b0;
        cyc = 0; seen = 0;
        while (cyc < 70000 && !seen) begin
            @(posedge clk);
            cyc++;
            #1 seen = done8;
        end
        chk(0, "w8 done latency", cyc, 65539);
        chk(0, "w8 sum_abs_err", longint'(sabs8), 64'd16711680);
        chk(0, "w8 sum_sq_err", longint'(ssq8), 64'd4977295360);
        chk(0, "w8 err_cnt", longint'(cnt8), 65535);
        chk(0, "w8 max_err", longint'(max8), 510);
        chk(0, "w8 wce_a", longint'(wa8), 255);
        chk(0, "w8 wce_b", longint'(wb8), 255);
        s8_fin = 1;
    end

    initial begin : finish_ctl
        int guard;
        guard = 0;
        while (!(s8_fin && s2_fin) && guard < 80000) begin
            @(posedge clk);
            guard++;
        end
        if (!(s8_fin && s2_fin)) chk(0, "global timeout", 0, 1);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
